store_buffer: RTL and testbench
===============================

# store_buffer

Parametrised store unit with a write-posting FIFO between the execute stage and data memory. It decodes RISC-V store width from `funct3`, builds byte-lane write enables and lane-replicated write data for a `DATA_W`-wide memory port, and buffers up to `DEPTH` stores. It drains them in order over a ready-qualified memory interface, so the core no longer stalls on slow DM/AXI writes. It also reports load-after-store hazards against pending entries.

## Interface
Parameters:
- `DATA_W`, 32: memory data width, 32 or 64; byte lanes `NB = DATA_W/8`, `AL = log2(NB)`.
- `ADDR_W`, 32: address width.
- `DEPTH`, 4: buffer entries, power of two, ≥2.

Ports:
- `i_clk` in 1: clock. One clock domain only.
- `i_rst` in 1: reset, asynchronous, active-high.
- `i_store` in 1: store request valid.
- `i_funct3` in 3: store width code. SB=000, SH=001, SW=010, SD=011.
- `i_ALUout` in ADDR_W: store byte address.
- `i_rs2_data` in DATA_W: store data.
- `o_st_ready` out 1: buffer can accept; equals `!o_full`.
- `o_DM_CS` out 1: head entry valid toward memory.
- `o_DM_WEB` out NB: byte write enables, active-low.
- `o_DM_addr` out ADDR_W: head entry address, unmodified.
- `o_DM_DI` out DATA_W: head entry lane-replicated data.
- `i_DM_ready` in 1: memory accepts the head entry this cycle.
- `i_ld_addr` in ADDR_W: address of the load in execute.
- `o_ld_hazard` out 1: a pending entry hits the same `NB`-byte word.
- `o_full` out 1: buffer full.
- `o_empty` out 1: buffer empty.
- `o_misalign` out 1: misaligned store rejected (see Configuration).

## Operation
- **Legal codes:** SB, SH, SW; SD only when `DATA_W==64`. Any other code is ignored and nothing is enqueued.
- **Enqueue:** occurs when `i_store && legal && o_st_ready`, and not rejected as misaligned. Each entry stores the address, data and WEB.
- **Lane build, with `lo = i_ALUout[AL-1:0]`:**
  - SB: data = `i_rs2_data[7:0]` replicated NB times; WEB lane `lo` = 0, others 1.
  - SH: data = halfword replicated; lanes `{lo[AL-1:1],0}` and `{lo[AL-1:1],1}` = 0. Bit `lo[0]` is ignored.
  - SW: data = word replicated; the 4 lanes at `{lo[AL-1:2],00}` = 0. When `DATA_W==32` this is WEB = 0000.
  - SD: all lanes 0.
- **Drain:**
  - `o_DM_CS = !o_empty`; the head fields drive the DM outputs.
  - A transfer completes on the edge where `o_DM_CS && i_DM_ready`; the read pointer then increments.
- **Idle outputs when empty:** `o_DM_WEB` all 1, `o_DM_DI` = 0, `o_DM_addr` = 0.
- **Occupancy:** `count`, width `log2(DEPTH)+1`, range 0..DEPTH. Pointers wrap modulo DEPTH.
- **Enqueue and dequeue in the same cycle:** allowed when not full, and `count` is unchanged. When full, `o_st_ready` = 0 even if a dequeue happens that cycle.
- **Hazard:** `o_ld_hazard` = 1 when any valid entry satisfies `addr[ADDR_W-1:AL] == i_ld_addr[ADDR_W-1:AL]`. Entries leaving this cycle still count. A store accepted in the same cycle is not compared. `o_ld_hazard` is combinational.
- **Ordering:** strictly FIFO; entries are never merged or reordered.

## Timing
- **Reset values:** pointers = 0, `count` = 0, `o_empty` = 1, `o_full` = 0, `o_st_ready` = 1, `o_DM_CS` = 0, WEB all 1, DI = 0, addr = 0, `o_ld_hazard` = 0, `o_misalign` = 0.
- **Reset mid-operation:** all pending stores are dropped; outputs take their reset values immediately.
- **Latency:** a store accepted at edge N, into an empty buffer, drives the DM outputs from after edge N, i.e. in cycle N+1.
- **Throughput:** sustained 1 store/cycle when `i_DM_ready` is held at 1.
- **DM outputs:** registered (entry storage plus head pointer); no combinational path from `i_store` to DM outputs.
- **Handshake:** DM outputs stay stable while `o_DM_CS && !i_DM_ready`.
- **Combinational outputs:** `o_st_ready`, `o_full` and `o_empty` depend only on `count`. `o_misalign` is combinational from the request inputs.

## Configuration
- **`STORE_MISALIGN_CHK_EN` defined:**
  - These stores are misaligned: SH with `lo[0]=1`, SW with `lo[1:0]!=0`, SD with `lo[2:0]!=0`.
  - A misaligned store with `i_store=1` drives `o_misalign=1` that same cycle and is not enqueued, regardless of `o_full`.
- **Not defined:**
  - `o_misalign` is tied to 0.
  - Misaligned stores are enqueued, with the offending low bits ignored for lane select per the lane-build rules.

## Test plan
- Reset, then SB with addr 0x1003 and rs2 0xAABBCCDD (`DATA_W`=32, `i_DM_ready`=1) -> the next cycle shows CS=1, WEB=0111, DI=0xDDDDDDDD, addr=0x1003; `o_empty`=1 after the following edge.
- Hold `i_DM_ready`=0 and issue 4 SW stores to 0x0, 0x4, 0x8, 0xC -> `o_full`=1, `o_st_ready`=0, a 5th store is dropped; releasing ready drains the addresses in order 0x0, 0x4, 0x8, 0xC, 1 per cycle.
- `DATA_W`=64, SH to 0x2006 with rs2 0x1234 -> WEB=00111111, DI=0x1234 replicated 4×.
- Pending SW at 0x100, `i_ld_addr`=0x102 -> `o_ld_hazard`=1; `i_ld_addr`=0x104 -> 0; after drain, 0x102 -> 0.
- With the macro, SW to 0x101 -> `o_misalign`=1 and `count` unchanged. Without the macro, the same store enqueues with WEB=0000.
- Assert `i_rst` mid-way with 3 pending entries -> `o_DM_CS`=0 and `o_empty`=1 immediately, and no further DM writes occur.

Source files
------------

// File: rtl/store_buffer.sv
// Store unit with a DEPTH-entry write-posting FIFO toward data memory.
// Define STORE_MISALIGN_CHK_EN to reject misaligned SH/SW/SD stores and flag them on o_misalign.
module store_buffer #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 32,
  parameter int DEPTH  = 4
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_store,
  input  logic [2:0]        i_funct3,
  input  logic [ADDR_W-1:0] i_ALUout,
  input  logic [DATA_W-1:0] i_rs2_data,
  output logic              o_st_ready,
  output logic              o_DM_CS,
  output logic [DATA_W/8-1:0] o_DM_WEB,
  output logic [ADDR_W-1:0] o_DM_addr,
  output logic [DATA_W-1:0] o_DM_DI,
  input  logic              i_DM_ready,
  input  logic [ADDR_W-1:0] i_ld_addr,
  output logic              o_ld_hazard,
  output logic              o_full,
  output logic              o_empty,
  output logic              o_misalign
);

  localparam int NB = DATA_W / 8;
  localparam int AL = $clog2(NB);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [CW-1:0]     count_q, count_d;
  logic [PW-1:0]     wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]     rd_ptr_q, rd_ptr_d;
  logic [ADDR_W-1:0] addr_mem_q [DEPTH];
  logic [ADDR_W-1:0] addr_mem_d [DEPTH];
  logic [DATA_W-1:0] data_mem_q [DEPTH];
  logic [DATA_W-1:0] data_mem_d [DEPTH];
  logic [NB-1:0]     web_mem_q  [DEPTH];
  logic [NB-1:0]     web_mem_d  [DEPTH];

  logic [AL-1:0]     lo;
  logic [AL-1:0]     off;
  logic [NB-1:0]     base;
  logic              legal;
  logic [DATA_W-1:0] st_data;
  logic [NB-1:0]     st_web;
  logic              misalign;
  logic              push;
  logic              pop;
  logic [PW-1:0]     rel;
  logic              unused_ld_lo;

  assign unused_ld_lo = ^i_ld_addr[AL-1:0];

  // Width decode: base lane mask is shifted to the naturally aligned lane group.
  always_comb begin
    lo      = i_ALUout[AL-1:0];
    legal   = 1'b0;
    base    = '0;
    off     = '0;
    st_data = '0;
    case (i_funct3)
      3'b000: begin
        legal   = 1'b1;
        base[0] = 1'b1;
        off     = lo;
        for (int i = 0; i < NB; i++) st_data[i*8 +: 8] = i_rs2_data[7:0];
      end
      3'b001: begin
        legal     = 1'b1;
        base[1:0] = 2'b11;
        off       = lo & ~AL'(1);
        for (int i = 0; i < NB; i++) st_data[i*8 +: 8] = i_rs2_data[(i%2)*8 +: 8];
      end
      3'b010: begin
        legal     = 1'b1;
        base[3:0] = 4'b1111;
        off       = lo & ~AL'(3);
        for (int i = 0; i < NB; i++) st_data[i*8 +: 8] = i_rs2_data[(i%4)*8 +: 8];
      end
      3'b011: begin
        legal   = (DATA_W == 64);
        base    = '1;
        st_data = i_rs2_data;
      end
      default: ;
    endcase
    st_web = ~(base << off);
  end

`ifdef STORE_MISALIGN_CHK_EN
  always_comb begin
    misalign = 1'b0;
    if (i_store && legal) begin
      case (i_funct3)
        3'b001:  misalign = i_ALUout[0];
        3'b010:  misalign = |i_ALUout[1:0];
        3'b011:  misalign = |i_ALUout[2:0];
        default: misalign = 1'b0;
      endcase
    end
  end
`else
  assign misalign = 1'b0;
`endif

  assign o_misalign = misalign;
  assign o_full     = (count_q == CW'(DEPTH));
  assign o_empty    = (count_q == '0);
  assign o_st_ready = !o_full;
  assign o_DM_CS    = !o_empty;

  assign push = i_store && legal && o_st_ready && !misalign;
  assign pop  = o_DM_CS && i_DM_ready;

  assign o_DM_WEB  = o_empty ? '1 : web_mem_q[rd_ptr_q];
  assign o_DM_DI   = o_empty ? '0 : data_mem_q[rd_ptr_q];
  assign o_DM_addr = o_empty ? '0 : addr_mem_q[rd_ptr_q];

  // An entry is pending when its distance from the read pointer is below count.
  always_comb begin
    o_ld_hazard = 1'b0;
    rel         = '0;
    for (int i = 0; i < DEPTH; i++) begin
      rel = PW'(i) - rd_ptr_q;
      if (({1'b0, rel} < count_q) &&
          (addr_mem_q[i][ADDR_W-1:AL] == i_ld_addr[ADDR_W-1:AL]))
        o_ld_hazard = 1'b1;
    end
  end

  always_comb begin
    addr_mem_d = addr_mem_q;
    data_mem_d = data_mem_q;
    web_mem_d  = web_mem_q;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    count_d    = count_q;
    if (push) begin
      addr_mem_d[wr_ptr_q] = i_ALUout;
      data_mem_d[wr_ptr_q] = st_data;
      web_mem_d[wr_ptr_q]  = st_web;
      wr_ptr_d             = wr_ptr_q + 1'b1;
    end
    if (pop) rd_ptr_d = rd_ptr_q + 1'b1;
    if (push && !pop)      count_d = count_q + 1'b1;
    else if (pop && !push) count_d = count_q - 1'b1;
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      count_q  <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        addr_mem_q[i] <= '0;
        data_mem_q[i] <= '0;
        web_mem_q[i]  <= '1;
      end
    end else begin
      count_q    <= count_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      addr_mem_q <= addr_mem_d;
      data_mem_q <= data_mem_d;
      web_mem_q  <= web_mem_d;
    end
  end

endmodule

// File: tb/tb_store_buffer.sv
// Self-checking bench for store_buffer: directed scenarios plus a randomized run
// against a queue-based model of the posted-store FIFO (32-bit and 64-bit instances).
module tb_store_buffer;

`ifdef STORE_MISALIGN_CHK_EN
  localparam bit CHK_EN = 1'b1;
`else
  localparam bit CHK_EN = 1'b0;
`endif

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, store, ready;
  logic [2:0]  f3;
  logic [31:0] alu, rs2, ld;
  logic        st_ready, cs, hazard, full, empty, misalign;
  logic [3:0]  web;
  logic [31:0] dm_addr, di;

  logic        store64, ready64;
  logic [2:0]  f3_64;
  logic [31:0] alu64, ld64;
  logic [63:0] rs2_64;
  logic        st_ready64, cs64, hazard64, full64, empty64, misalign64;
  logic [7:0]  web64;
  logic [31:0] dm_addr64;
  logic [63:0] di64;

  store_buffer #(.DATA_W(32), .ADDR_W(32), .DEPTH(4)) dut (
    .i_clk(clk), .i_rst(rst), .i_store(store), .i_funct3(f3), .i_ALUout(alu),
    .i_rs2_data(rs2), .o_st_ready(st_ready), .o_DM_CS(cs), .o_DM_WEB(web),
    .o_DM_addr(dm_addr), .o_DM_DI(di), .i_DM_ready(ready), .i_ld_addr(ld),
    .o_ld_hazard(hazard), .o_full(full), .o_empty(empty), .o_misalign(misalign)
  );

  store_buffer #(.DATA_W(64), .ADDR_W(32), .DEPTH(4)) dut64 (
    .i_clk(clk), .i_rst(rst), .i_store(store64), .i_funct3(f3_64), .i_ALUout(alu64),
    .i_rs2_data(rs2_64), .o_st_ready(st_ready64), .o_DM_CS(cs64), .o_DM_WEB(web64),
    .o_DM_addr(dm_addr64), .o_DM_DI(di64), .i_DM_ready(ready64), .i_ld_addr(ld64),
    .o_ld_hazard(hazard64), .o_full(full64), .o_empty(empty64), .o_misalign(misalign64)
  );

  typedef struct {
    logic [31:0] addr;
    logic [31:0] data;
    logic [3:0]  web;
  } ent_t;

  ent_t mq[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  function automatic bit m_legal(input logic [2:0] code);
    return code <= 3'd2;
  endfunction

  function automatic bit m_mis(input logic st, input logic [2:0] code, input logic [31:0] a);
    if (!CHK_EN || !st) return 1'b0;
    if (code == 3'd1) return a[0];
    if (code == 3'd2) return a[1:0] != 2'b00;
    return 1'b0;
  endfunction

  // A lane is written when it falls in the same size-aligned group as the address.
  function automatic logic [3:0] m_web(input logic [2:0] code, input logic [31:0] a);
    int sz = 1 << code;
    int lo = int'(a[1:0]);
    logic [3:0] w;
    for (int l = 0; l < 4; l++) w[l] = !((l / sz) == (lo / sz));
    return w;
  endfunction

  function automatic logic [31:0] m_data(input logic [2:0] code, input logic [31:0] d);
    int sz = 1 << code;
    logic [31:0] r;
    for (int l = 0; l < 4; l++) r[l*8 +: 8] = d[(l % sz)*8 +: 8];
    return r;
  endfunction

  // Advance one clock, applying the model's accept/drain decisions for this cycle.
  task automatic tick();
    bit   do_pop, do_push;
    ent_t e;
    do_pop  = (mq.size() > 0) && ready;
    do_push = store && m_legal(f3) && (mq.size() < 4) && !m_mis(store, f3, alu);
    e.addr  = alu;
    e.data  = m_data(f3, rs2);
    e.web   = m_web(f3, alu);
    @(posedge clk);
    if (rst) mq.delete();
    else begin
      if (do_pop) void'(mq.pop_front());
      if (do_push) mq.push_back(e);
    end
    #1;
  endtask

  task automatic idle_inputs();
    store = 1'b0; f3 = 3'd0; alu = '0; rs2 = '0; ready = 1'b0; ld = '0;
    store64 = 1'b0; f3_64 = 3'd0; alu64 = '0; rs2_64 = '0; ready64 = 1'b0; ld64 = '0;
  endtask

  task automatic do_reset();
    idle_inputs();
    rst = 1'b1;
    mq.delete();
    tick();
    tick();
    rst = 1'b0;
    #1;
  endtask

  task automatic test_reset();
    idle_inputs();
    rst = 1'b1;
    mq.delete();
    #2;
    n_checks++; if (empty !== 1'b1) begin n_fail++; $display("[TB] FAIL reset_empty got=%b exp=1", empty); end
    n_checks++; if (full !== 1'b0) begin n_fail++; $display("[TB] FAIL reset_full got=%b exp=0", full); end
    n_checks++; if (st_ready !== 1'b1) begin n_fail++; $display("[TB] FAIL reset_st_ready got=%b exp=1", st_ready); end
    n_checks++; if (cs !== 1'b0) begin n_fail++; $display("[TB] FAIL reset_cs got=%b exp=0", cs); end
    n_checks++; if (web !== 4'hF) begin n_fail++; $display("[TB] FAIL reset_web got=%h exp=f", web); end
    n_checks++; if (di !== 32'h0) begin n_fail++; $display("[TB] FAIL reset_di got=%h exp=0", di); end
    n_checks++; if (dm_addr !== 32'h0) begin n_fail++; $display("[TB] FAIL reset_addr got=%h exp=0", dm_addr); end
    n_checks++; if (hazard !== 1'b0) begin n_fail++; $display("[TB] FAIL reset_hazard got=%b exp=0", hazard); end
    n_checks++; if (misalign !== 1'b0) begin n_fail++; $display("[TB] FAIL reset_misalign got=%b exp=0", misalign); end
    n_checks++; if (web64 !== 8'hFF) begin n_fail++; $display("[TB] FAIL reset_web64 got=%h exp=ff", web64); end
    tick();
    rst = 1'b0;
    #1;
  endtask

  task automatic test_sb_latency();
    do_reset();
    ready = 1'b1; store = 1'b1; f3 = 3'b000; alu = 32'h1003; rs2 = 32'hAABBCCDD;
    #1;
    tick();
    store = 1'b0;
    #1;
    n_checks++; if (cs !== 1'b1) begin n_fail++; $display("[TB] FAIL sb_cs got=%b exp=1", cs); end
    n_checks++; if (web !== 4'b0111) begin n_fail++; $display("[TB] FAIL sb_web got=%b exp=0111", web); end
    n_checks++; if (di !== 32'hDDDDDDDD) begin n_fail++; $display("[TB] FAIL sb_di got=%h exp=dddddddd", di); end
    n_checks++; if (dm_addr !== 32'h1003) begin n_fail++; $display("[TB] FAIL sb_addr got=%h exp=1003", dm_addr); end
    tick();
    n_checks++; if (empty !== 1'b1) begin n_fail++; $display("[TB] FAIL sb_drained got=%b exp=1", empty); end
  endtask

  task automatic test_fill_drain();
    do_reset();
    ready = 1'b0;
    for (int k = 0; k < 5; k++) begin
      store = 1'b1; f3 = 3'b010; alu = 32'(4 * k); rs2 = $urandom;
      #1;
      tick();
    end
    store = 1'b0;
    #1;
    n_checks++; if (full !== 1'b1) begin n_fail++; $display("[TB] FAIL fill_full got=%b exp=1", full); end
    n_checks++; if (st_ready !== 1'b0) begin n_fail++; $display("[TB] FAIL fill_st_ready got=%b exp=0", st_ready); end
    n_checks++; if (web !== 4'b0000) begin n_fail++; $display("[TB] FAIL fill_web got=%b exp=0000", web); end
    ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      #1;
      n_checks++; if (cs !== 1'b1 || dm_addr !== 32'(4 * k)) begin
        n_fail++; $display("[TB] FAIL drain_order[%0d] got cs=%b addr=%h exp cs=1 addr=%h", k, cs, dm_addr, 32'(4 * k));
      end
      tick();
    end
    n_checks++; if (empty !== 1'b1) begin n_fail++; $display("[TB] FAIL drain_fifth_dropped empty got=%b exp=1", empty); end
  endtask

  task automatic test_hazard();
    do_reset();
    ready = 1'b0; store = 1'b1; f3 = 3'b010; alu = 32'h100; rs2 = 32'h0; ld = 32'h100;
    #1;
    n_checks++; if (hazard !== 1'b0) begin n_fail++; $display("[TB] FAIL haz_same_cycle got=%b exp=0", hazard); end
    tick();
    store = 1'b0; ld = 32'h102;
    #1;
    n_checks++; if (hazard !== 1'b1) begin n_fail++; $display("[TB] FAIL haz_hit got=%b exp=1", hazard); end
    ld = 32'h104;
    #1;
    n_checks++; if (hazard !== 1'b0) begin n_fail++; $display("[TB] FAIL haz_next_word got=%b exp=0", hazard); end
    ready = 1'b1; ld = 32'h102;
    #1;
    n_checks++; if (hazard !== 1'b1) begin n_fail++; $display("[TB] FAIL haz_leaving got=%b exp=1", hazard); end
    tick();
    n_checks++; if (hazard !== 1'b0) begin n_fail++; $display("[TB] FAIL haz_after_drain got=%b exp=0", hazard); end
  endtask

  task automatic test_misalign();
    do_reset();
    ready = 1'b0; store = 1'b1; f3 = 3'b010; alu = 32'h101; rs2 = 32'h01020304;
    #1;
    n_checks++; if (misalign !== CHK_EN) begin n_fail++; $display("[TB] FAIL mis_flag got=%b exp=%b", misalign, CHK_EN); end
    tick();
    store = 1'b0;
    #1;
    n_checks++; if (empty !== CHK_EN) begin n_fail++; $display("[TB] FAIL mis_enqueue empty got=%b exp=%b", empty, CHK_EN); end
    n_checks++; if (web !== (CHK_EN ? 4'hF : 4'h0)) begin
      n_fail++; $display("[TB] FAIL mis_web got=%b exp=%b", web, CHK_EN ? 4'hF : 4'h0);
    end
  endtask

  task automatic test_wide64();
    do_reset();
    store64 = 1'b1; f3_64 = 3'b001; alu64 = 32'h2006; rs2_64 = 64'h1234;
    #1;
    tick();
    store64 = 1'b0;
    #1;
    n_checks++; if (web64 !== 8'b00111111) begin n_fail++; $display("[TB] FAIL sh64_web got=%b exp=00111111", web64); end
    n_checks++; if (di64 !== 64'h1234123412341234) begin n_fail++; $display("[TB] FAIL sh64_di got=%h exp=1234123412341234", di64); end
    n_checks++; if (dm_addr64 !== 32'h2006 || cs64 !== 1'b1) begin
      n_fail++; $display("[TB] FAIL sh64_head got cs=%b addr=%h exp cs=1 addr=2006", cs64, dm_addr64);
    end
    ready64 = 1'b1; store64 = 1'b1; f3_64 = 3'b011; alu64 = 32'h3000; rs2_64 = 64'h1122334455667788;
    #1;
    tick();
    store64 = 1'b0;
    #1;
    n_checks++; if (web64 !== 8'h00 || di64 !== 64'h1122334455667788) begin
      n_fail++; $display("[TB] FAIL sd64_head got web=%b di=%h exp web=00000000 di=1122334455667788", web64, di64);
    end
    tick();
    n_checks++; if (empty64 !== 1'b1) begin n_fail++; $display("[TB] FAIL sd64_drained got=%b exp=1", empty64); end
    ready64 = 1'b0;
  endtask

  task automatic test_random();
    logic [3:0]  e_web;
    logic [31:0] e_di, e_addr;
    logic        e_haz;
    do_reset();
    for (int n = 0; n < 400; n++) begin
      store = ($urandom_range(0, 3) != 0);
      f3    = ($urandom_range(0, 7) == 0) ? 3'($urandom_range(3, 7)) : 3'($urandom_range(0, 2));
      alu   = 32'h1000 + ($urandom & 32'h1F);
      ld    = 32'h1000 + ($urandom & 32'h1F);
      rs2   = $urandom;
      ready = (n < 200) ? ($urandom_range(0, 2) == 0) : ($urandom_range(0, 2) != 0);
      #1;
      e_web  = (mq.size() > 0) ? mq[0].web  : 4'hF;
      e_di   = (mq.size() > 0) ? mq[0].data : 32'h0;
      e_addr = (mq.size() > 0) ? mq[0].addr : 32'h0;
      e_haz  = 1'b0;
      foreach (mq[k]) if (mq[k].addr[31:2] == ld[31:2]) e_haz = 1'b1;
      n_checks++; if (cs !== (mq.size() > 0) || empty !== (mq.size() == 0) || full !== (mq.size() == 4) || st_ready !== (mq.size() < 4)) begin
        n_fail++; $display("[TB] FAIL rnd_status[%0d] got cs=%b empty=%b full=%b rdy=%b exp occupancy=%0d", n, cs, empty, full, st_ready, mq.size());
      end
      n_checks++; if (web !== e_web || di !== e_di || dm_addr !== e_addr) begin
        n_fail++; $display("[TB] FAIL rnd_head[%0d] got web=%b di=%h addr=%h exp web=%b di=%h addr=%h", n, web, di, dm_addr, e_web, e_di, e_addr);
      end
      n_checks++; if (hazard !== e_haz) begin n_fail++; $display("[TB] FAIL rnd_hazard[%0d] got=%b exp=%b", n, hazard, e_haz); end
      n_checks++; if (misalign !== m_mis(store, f3, alu)) begin
        n_fail++; $display("[TB] FAIL rnd_misalign[%0d] got=%b exp=%b", n, misalign, m_mis(store, f3, alu));
      end
      tick();
    end
  endtask

  task automatic test_reset_midway();
    do_reset();
    ready = 1'b0;
    for (int k = 0; k < 3; k++) begin
      store = 1'b1; f3 = 3'b010; alu = 32'h40 + 32'(4 * k); rs2 = $urandom;
      #1;
      tick();
    end
    store = 1'b0;
    #2;
    rst = 1'b1;
    #1;
    n_checks++; if (cs !== 1'b0 || empty !== 1'b1) begin
      n_fail++; $display("[TB] FAIL midrst_immediate got cs=%b empty=%b exp cs=0 empty=1", cs, empty);
    end
    n_checks++; if (web !== 4'hF) begin n_fail++; $display("[TB] FAIL midrst_web got=%b exp=1111", web); end
    mq.delete();
    tick();
    rst = 1'b0;
    ready = 1'b1;
    for (int k = 0; k < 3; k++) begin
      #1;
      n_checks++; if (cs !== 1'b0) begin n_fail++; $display("[TB] FAIL midrst_no_write[%0d] got cs=%b exp=0", k, cs); end
      tick();
    end
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog timeout");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    rst = 1'b1;
    idle_inputs();
    test_reset();
    test_sb_latency();
    test_fill_drain();
    test_hazard();
    test_misalign();
    test_wide64();
    test_random();
    test_reset_midway();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
